// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard detection, forwarding select and stall/flush control for a 5-stage pipeline,
// tracking E/M/W control records plus retired-instruction and hazard-stall counters.
module pipe_ctrl #(
    parameter int AW     = 5,
    parameter int CNT_W  = 32,
    parameter int FWD_EN = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_d_i,
    input  logic [AW-1:0]    rs1_d_i,
    input  logic [AW-1:0]    rs2_d_i,
    input  logic [AW-1:0]    rd_d_i,
    input  logic             regwrite_d_i,
    input  logic             load_d_i,
    input  logic             redirect_e_i,
    input  logic             ext_stall_i,
    output logic             stall_f_o,
    output logic             stall_d_o,
    output logic             flush_d_o,
    output logic             flush_e_o,
    output logic [1:0]       fwd_a_e_o,
    output logic [1:0]       fwd_b_e_o,
    output logic             valid_w_o,
    output logic [CNT_W-1:0] retired_o,
    output logic [CNT_W-1:0] hazard_cnt_o
);
    typedef struct packed {
        logic          v;
        logic          rw;
        logic          ld;
        logic [AW-1:0] rd;
    } st_t;

    st_t              e_q, e_d, m_q, w_q;
    logic [AW-1:0]    e_rs1_q, e_rs1_d, e_rs2_q, e_rs2_d;
    logic [CNT_W-1:0] retired_q, hazard_q;
    logic             e_hit, m_hit, haz, kill;

    function automatic logic wr(input st_t s, input logic [AW-1:0] r);
        return s.v && s.rw && s.rd == r && r != '0;
    endfunction

    function automatic logic [1:0] fwd(input st_t m, input st_t w, input logic [AW-1:0] r);
        return FWD_EN == 0 ? 2'b00 : (wr(m, r) && !m.ld) ? 2'b10 : wr(w, r) ? 2'b01 : 2'b00;
    endfunction

    assign e_hit = wr(e_q, rs1_d_i) || wr(e_q, rs2_d_i);
    assign m_hit = wr(m_q, rs1_d_i) || wr(m_q, rs2_d_i);
    // Without forwarding every in-flight E/M producer blocks; with it only a load in E does.
    assign haz   = valid_d_i && (FWD_EN != 0 ? (e_q.ld && e_hit) : (e_hit || m_hit));
    assign kill  = redirect_e_i || haz;

    assign stall_f_o    = rst_i && (ext_stall_i || (!redirect_e_i && haz));
    assign stall_d_o    = stall_f_o;
    assign flush_d_o    = rst_i && !ext_stall_i && redirect_e_i;
    assign flush_e_o    = rst_i && !ext_stall_i && kill;
    assign fwd_a_e_o    = fwd(m_q, w_q, e_rs1_q);
    assign fwd_b_e_o    = fwd(m_q, w_q, e_rs2_q);
    assign valid_w_o    = w_q.v;
    assign retired_o    = retired_q;
    assign hazard_cnt_o = hazard_q;

    always_comb begin
        e_d     = kill ? '0 : '{v: valid_d_i, rw: regwrite_d_i, ld: load_d_i, rd: rd_d_i};
        e_rs1_d = kill ? '0 : rs1_d_i;
        e_rs2_d = kill ? '0 : rs2_d_i;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            e_q       <= '0;
            m_q       <= '0;
            w_q       <= '0;
            e_rs1_q   <= '0;
            e_rs2_q   <= '0;
            retired_q <= '0;
            hazard_q  <= '0;
        end else if (!ext_stall_i) begin
            e_q       <= e_d;
            e_rs1_q   <= e_rs1_d;
            e_rs2_q   <= e_rs2_d;
            m_q       <= e_q;
            w_q       <= m_q;
            retired_q <= retired_q + CNT_W'(w_q.v);
            hazard_q  <= hazard_q + CNT_W'(!redirect_e_i && haz);
        end
    end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: three pipe_ctrl variants (forwarding, stall-only, 4-bit counters) checked every cycle
// against a queue-of-records reference model, plus directed scenarios with literal expectations.
module tb_pipe_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, vd, rw, ld, redir, ext;
    logic [4:0] rs1, rs2, rd;
    logic       sf[3], sd[3], fdo[3], feo[3], vw[3];
    logic [1:0] fa[3], fb[3];
    logic [31:0] rt0, rt1, hc0, hc1;
    logic [3:0]  rt2, hc2;

    pipe_ctrl #(.AW(5), .CNT_W(32), .FWD_EN(1)) u0 (
        .clk_i(clk), .rst_i(rst), .valid_d_i(vd), .rs1_d_i(rs1), .rs2_d_i(rs2), .rd_d_i(rd),
        .regwrite_d_i(rw), .load_d_i(ld), .redirect_e_i(redir), .ext_stall_i(ext),
        .stall_f_o(sf[0]), .stall_d_o(sd[0]), .flush_d_o(fdo[0]), .flush_e_o(feo[0]),
        .fwd_a_e_o(fa[0]), .fwd_b_e_o(fb[0]), .valid_w_o(vw[0]), .retired_o(rt0), .hazard_cnt_o(hc0));
    pipe_ctrl #(.AW(5), .CNT_W(32), .FWD_EN(0)) u1 (
        .clk_i(clk), .rst_i(rst), .valid_d_i(vd), .rs1_d_i(rs1), .rs2_d_i(rs2), .rd_d_i(rd),
        .regwrite_d_i(rw), .load_d_i(ld), .redirect_e_i(redir), .ext_stall_i(ext),
        .stall_f_o(sf[1]), .stall_d_o(sd[1]), .flush_d_o(fdo[1]), .flush_e_o(feo[1]),
        .fwd_a_e_o(fa[1]), .fwd_b_e_o(fb[1]), .valid_w_o(vw[1]), .retired_o(rt1), .hazard_cnt_o(hc1));
    pipe_ctrl #(.AW(5), .CNT_W(4), .FWD_EN(1)) u2 (
        .clk_i(clk), .rst_i(rst), .valid_d_i(vd), .rs1_d_i(rs1), .rs2_d_i(rs2), .rd_d_i(rd),
        .regwrite_d_i(rw), .load_d_i(ld), .redirect_e_i(redir), .ext_stall_i(ext),
        .stall_f_o(sf[2]), .stall_d_o(sd[2]), .flush_d_o(fdo[2]), .flush_e_o(feo[2]),
        .fwd_a_e_o(fa[2]), .fwd_b_e_o(fb[2]), .valid_w_o(vw[2]), .retired_o(rt2), .hazard_cnt_o(hc2));

    typedef struct packed {
        logic       v;
        logic       rw;
        logic       ld;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } rec_t;

    // Model pipeline per instance: pipe[k][0]=E, [1]=M, [2]=W
    rec_t        pipe[3][3];
    int unsigned mret[3], mhaz[3];
    int          total = 0, bad = 0;

    function automatic logic [31:0] rtk(int k);
        return k == 0 ? rt0 : k == 1 ? rt1 : {28'd0, rt2};
    endfunction

    function automatic logic [31:0] hck(int k);
        return k == 0 ? hc0 : k == 1 ? hc1 : {28'd0, hc2};
    endfunction

    function automatic bit writes(rec_t s, logic [4:0] r);
        return s.v && s.rw && s.rd == r && r != 0;
    endfunction

    function automatic bit needs_stall(int k);
        bit dep_e = writes(pipe[k][0], rs1) || writes(pipe[k][0], rs2);
        bit dep_m = writes(pipe[k][1], rs1) || writes(pipe[k][1], rs2);
        if (!vd) return 0;
        return k == 1 ? (dep_e || dep_m) : (pipe[k][0].ld && dep_e);
    endfunction

    function automatic logic [1:0] src(int k, logic [4:0] r);
        if (k == 1) return 2'b00;
        if (writes(pipe[k][1], r) && !pipe[k][1].ld) return 2'b10;
        if (writes(pipe[k][2], r)) return 2'b01;
        return 2'b00;
    endfunction

    task automatic chk(string n, int k, logic [31:0] a, logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s u%0d got=%0h exp=%0h t=%0t", n, k, a, e, $time);
        end
    endtask

    task automatic zero_model();
        for (int k = 0; k < 3; k++) begin
            for (int s = 0; s < 3; s++) pipe[k][s] = '0;
            mret[k] = 0;
            mhaz[k] = 0;
        end
    endtask

    task automatic compare();
        if (!rst) zero_model();
        for (int k = 0; k < 3; k++) begin
            bit h = rst && needs_stall(k);
            bit st = rst && (ext || (!redir && h));
            chk("stall_f", k, sf[k], st);
            chk("stall_d", k, sd[k], st);
            chk("flush_d", k, fdo[k], rst && !ext && redir);
            chk("flush_e", k, feo[k], rst && !ext && (redir || h));
            chk("fwd_a", k, fa[k], src(k, pipe[k][0].rs1));
            chk("fwd_b", k, fb[k], src(k, pipe[k][0].rs2));
            chk("valid_w", k, vw[k], pipe[k][2].v);
            chk("retired", k, rtk(k), k == 2 ? mret[k] % 16 : mret[k]);
            chk("hazard_cnt", k, hck(k), k == 2 ? mhaz[k] % 16 : mhaz[k]);
        end
    endtask

    task automatic advance();
        rec_t n;
        n = '{v: vd, rw: rw, ld: ld, rd: rd, rs1: rs1, rs2: rs2};
        if (!rst) zero_model();
        else if (!ext)
            for (int k = 0; k < 3; k++) begin
                bit h = needs_stall(k);
                mret[k] += pipe[k][2].v;
                if (!redir && h) mhaz[k]++;
                pipe[k][2] = pipe[k][1];
                pipe[k][1] = pipe[k][0];
                pipe[k][0] = (redir || h) ? rec_t'(0) : n;
            end
    endtask

    task automatic cyc();
        @(negedge clk);
        compare();
        @(posedge clk);
        advance();
        #1;
    endtask

    task automatic dr(bit v, logic [4:0] a, logic [4:0] b, logic [4:0] d, bit w, bit l);
        vd = v; rs1 = a; rs2 = b; rd = d; rw = w; ld = l;
    endtask

    task automatic idle();
        dr(0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst = 0; redir = 1; ext = 1;
        dr(1, 1, 1, 1, 1, 1);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("rst_stall_f", k, sf[k], 0);
            chk("rst_stall_d", k, sd[k], 0);
            chk("rst_flush_d", k, fdo[k], 0);
            chk("rst_flush_e", k, feo[k], 0);
            chk("rst_fwd_a", k, fa[k], 0);
            chk("rst_valid_w", k, vw[k], 0);
            chk("rst_retired", k, rtk(k), 0);
        end
        cyc();
        rst = 1; redir = 0; ext = 0;
        idle();
    endtask

    initial begin
        rst = 0; redir = 0; ext = 0;
        idle();
        zero_model();
        do_reset();

        // load-use with forwarding
        dr(1, 0, 0, 5, 1, 1); cyc();
        dr(1, 5, 6, 7, 1, 0); #1;
        chk("lu_stall_f", 0, sf[0], 1);
        chk("lu_stall_d", 0, sd[0], 1);
        chk("lu_flush_e", 0, feo[0], 1);
        chk("lu_flush_d", 0, fdo[0], 0);
        cyc();
        chk("lu_hazard_cnt", 0, hc0, 1);
        chk("lu_released", 0, sf[0], 0);
        cyc(); idle(); #1;
        chk("lu_fwd_a", 0, fa[0], 2'b01);
        cyc(); cyc();

        // ALU chain, forwarding
        do_reset();
        dr(1, 0, 0, 3, 1, 0); cyc();
        dr(1, 0, 3, 4, 1, 0); #1;
        chk("alu_no_stall", 0, sf[0], 0);
        cyc(); idle(); #1;
        chk("alu_fwd_b", 0, fb[0], 2'b10);
        cyc(); cyc();

        // ALU chain, stall-only
        do_reset();
        dr(1, 0, 0, 3, 1, 0); cyc();
        dr(1, 0, 3, 4, 1, 0); #1;
        chk("nf_stall1", 1, sf[1], 1);
        cyc(); #1;
        chk("nf_stall2", 1, sf[1], 1);
        cyc(); #1;
        chk("nf_stall3", 1, sf[1], 0);
        chk("nf_hazard_cnt", 1, hc1, 2);
        cyc(); idle(); #1;
        chk("nf_fwd_a", 1, fa[1], 0);
        chk("nf_fwd_b", 1, fb[1], 0);
        cyc();

        // zero register is never a producer
        do_reset();
        dr(1, 0, 0, 0, 1, 0); cyc();
        dr(1, 0, 0, 1, 1, 0); #1;
        chk("x0_stall_fwd", 0, sf[0], 0);
        chk("x0_stall_nofwd", 1, sf[1], 0);
        cyc(); idle(); #1;
        chk("x0_fwd_a", 0, fa[0], 0);
        chk("x0_fwd_b", 0, fb[0], 0);
        cyc();

        // redirect coincident with load-use
        do_reset();
        dr(1, 0, 0, 5, 1, 1); cyc();
        dr(1, 5, 0, 7, 1, 0); redir = 1; #1;
        chk("rd_flush_d", 0, fdo[0], 1);
        chk("rd_flush_e", 0, feo[0], 1);
        chk("rd_stall_d", 0, sd[0], 0);
        chk("rd_stall_f", 0, sf[0], 0);
        cyc(); redir = 0; idle(); #1;
        chk("rd_hazard_cnt", 0, hc0, 0);
        cyc();
        chk("rd_load_in_w", 0, vw[0], 1);
        cyc();
        chk("rd_bubble_w", 0, vw[0], 0);

        // external freeze
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            dr(1, 0, 0, 5'(i), 1, 0); cyc();
        end
        idle(); ext = 1;
        repeat (3) cyc();
        chk("ext_valid_w", 0, vw[0], 1);
        chk("ext_retired_frozen", 0, rt0, 0);
        ext = 0;
        repeat (3) cyc();
        chk("ext_retired", 0, rt0, 3);
        chk("ext_hazard_cnt", 0, hc0, 0);

        // counter wrap, then reset mid-stream
        do_reset();
        repeat (17) begin
            dr(1, 0, 0, 1, 1, 0); cyc();
        end
        idle();
        repeat (3) cyc();
        chk("wrap_retired4", 2, {28'd0, rt2}, 1);
        chk("wrap_retired32", 0, rt0, 17);
        dr(1, 0, 0, 2, 1, 0);
        repeat (2) cyc();
        do_reset();

        // randomized traffic
        repeat (3000) begin
            rst   = $urandom_range(299) != 0;
            vd    = $urandom_range(3) != 0;
            rs1   = 5'($urandom_range(7));
            rs2   = 5'($urandom_range(7));
            rd    = 5'($urandom_range(7));
            rw    = $urandom_range(3) != 0;
            ld    = $urandom_range(2) == 0;
            redir = $urandom_range(7) == 0;
            ext   = $urandom_range(7) == 0;
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
